snd_out_filter: RTL and testbench

- Audio output conditioning stage. Sits directly downstream of the three-POKEY sound mixer.
- Consumes the mixer's 16-bit unsigned, DC-offset sum (10-bit data left-justified, low 6 bits zero) at system clock rate.
- Produces a signed 16-bit PCM stream at a fixed sample rate for the framework audio output. Processing chain: decimating sample strobe, DC-blocking high-pass, one-pole low-pass (POKEY alias smoothing), volume gain with saturation, mute.

---
 rtl/snd_pkg.sv | 28 ++
 rtl/sample_tick_gen.sv | 32 +++
 rtl/snd_out_filter.sv | 88 ++++++++
 tb/tb_snd_out_filter.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/snd_pkg.sv
// Shared types, constants and helpers for the sound output path.
package snd_pkg;

  localparam int ACC_W      = 24;
  localparam int PCM_W      = 16;
  localparam int PROD_W     = 28;
  localparam int GAIN_UNITY = 8;
  localparam int GAIN_SHIFT = $clog2(GAIN_UNITY);

  localparam logic signed [PROD_W-1:0] SAT_MAX = 28'sd32767;
  localparam logic signed [PROD_W-1:0] SAT_MIN = -28'sd32768;

  function automatic logic signed [PCM_W-1:0] sat16(input logic signed [PROD_W-1:0] v);
    if (v > SAT_MAX) begin
      return 16'sh7FFF;
    end else if (v < SAT_MIN) begin
      return 16'sh8000;
    end else begin
      return v[PCM_W-1:0];
    end
  endfunction

  // Subtracting the 0x8000 offset is an MSB flip; the result is then sign-extended.
  function automatic logic signed [ACC_W-1:0] to_signed_pcm(input logic [PCM_W-1:0] u);
    return {{(ACC_W-PCM_W){~u[PCM_W-1]}}, ~u[PCM_W-1], u[PCM_W-2:0]};
  endfunction

endpackage

// File: rtl/sample_tick_gen.sv
// Fractional-N sample strobe: one-cycle tick at SAMPLE_HZ average rate from CLK_HZ.
module sample_tick_gen #(
  parameter int unsigned CLK_HZ    = 12_000_000,
  parameter int unsigned SAMPLE_HZ = 48_000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  logic [31:0] r_phase;
  logic        r_tick;
  logic [31:0] w_sum;

  assign w_sum = r_phase + SAMPLE_HZ;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_phase <= '0;
      r_tick  <= 1'b0;
    end else if (w_sum >= CLK_HZ) begin
      r_phase <= w_sum - CLK_HZ;
      r_tick  <= 1'b1;
    end else begin
      r_phase <= w_sum;
      r_tick  <= 1'b0;
    end
  end

  assign tick = r_tick;

endmodule

// File: rtl/snd_out_filter.sv
// Mixer-to-PCM conditioning: decimate, DC-block, low-pass, gain/saturate, mute.
module snd_out_filter
  import snd_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 12_000_000,
  parameter int unsigned SAMPLE_HZ = 48_000,
  parameter int          DC_SHIFT  = 10,
  parameter int          LP_SHIFT  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PCM_W-1:0] snd_in,
  input  logic [3:0]       gain,
  input  logic             mute,
  output logic [PCM_W-1:0] pcm_out,
  output logic             pcm_valid
);

  // The single-issue pipeline relies on ticks being at least four cycles apart.
  if (64'(SAMPLE_HZ) * 64'd4 > 64'(CLK_HZ)) begin : g_badRate
    $error("snd_out_filter: SAMPLE_HZ*4 must not exceed CLK_HZ");
  end

  logic                     w_tick;
  logic signed [ACC_W-1:0]  w_x;
  logic signed [ACC_W-1:0]  w_yNew;
  logic signed [ACC_W-1:0]  w_zNext;
  logic signed [28:0]       w_zWide;
  logic signed [28:0]       w_gainWide;
  logic signed [28:0]       w_prod;
  logic signed [PROD_W-1:0] w_p;

  logic signed [ACC_W-1:0]  r_xPrev;
  logic signed [ACC_W-1:0]  r_y;
  logic signed [ACC_W-1:0]  r_z;
  logic                     r_v1;
  logic                     r_v2;
  logic                     r_v3;
  logic        [PCM_W-1:0]  r_pcm;

  sample_tick_gen #(
    .CLK_HZ   (CLK_HZ),
    .SAMPLE_HZ(SAMPLE_HZ)
  ) u_tick (
    .clk (clk),
    .rst (rst),
    .tick(w_tick)
  );

  assign w_x        = to_signed_pcm(snd_in);
  assign w_yNew     = w_x - r_xPrev + r_y - (r_y >>> DC_SHIFT);
  assign w_zNext    = r_z + ((r_y - r_z) >>> LP_SHIFT);
  assign w_zWide    = 29'(r_z);
  assign w_gainWide = {25'd0, gain};
  assign w_prod     = w_zWide * w_gainWide;
  assign w_p        = PROD_W'(w_prod >>> GAIN_SHIFT);

  // Stage 1 on the tick, stage 2 one cycle later, output register one cycle after that.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_xPrev <= '0;
      r_y     <= '0;
      r_z     <= '0;
      r_v1    <= 1'b0;
      r_v2    <= 1'b0;
      r_v3    <= 1'b0;
      r_pcm   <= '0;
    end else begin
      r_v1 <= w_tick;
      r_v2 <= r_v1;
      r_v3 <= r_v2;
      if (w_tick) begin
        r_xPrev <= w_x;
        r_y     <= w_yNew;
      end
      if (r_v1) begin
        r_z <= w_zNext;
      end
      if (r_v2) begin
        r_pcm <= mute ? '0 : sat16(w_p);
      end
    end
  end

  assign pcm_out   = r_pcm;
  assign pcm_valid = r_v3;

endmodule

// File: tb/tb_snd_out_filter.sv
// Scoreboard bench for snd_out_filter: driver pushes expected samples, monitor pops on pcm_valid.
module tb_snd_out_filter;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] snd_in;
  logic [3:0]  gain;
  logic        mute;
  logic [15:0] pcm_out;
  logic        pcm_valid;

  snd_out_filter dut (
    .clk      (clk),
    .rst      (rst),
    .snd_in   (snd_in),
    .gain     (gain),
    .mute     (mute),
    .pcm_out  (pcm_out),
    .pcm_valid(pcm_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    int    pcm;
    int    cyc;
    string name;
    bit    mono;
  } exp_t;

  exp_t        sb[$];
  exp_t        monE;
  int          compared   = 0;
  int          mismatched = 0;
  int          cyc        = 0;
  int          sampIdx    = 0;
  int          mX = 0, mY = 0, mZ = 0;
  int          prevValidOut = 0;
  logic [15:0] heldOut = '0;

  localparam int TICK_CYC = 250;

  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic checkOutput(input string name, input int actual, input int required);
    compared++;
    if (actual != required) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, required, cyc);
    end
  endtask

  // Reference filter in plain integer arithmetic; values stay far inside 24 bits.
  function automatic int modelStep(input logic [15:0] s, input logic [3:0] g, input logic m);
    int x, yNew, p;
    x    = int'(s) - 32768;
    yNew = x - mX + mY - (mY >>> 10);
    mX   = x;
    mY   = yNew;
    mZ   = mZ + ((mY - mZ) >>> 1);
    p    = (mZ * int'(g)) >>> 3;
    if (p > 32767)       p = 32767;
    else if (p < -32768) p = -32768;
    return m ? 0 : p;
  endfunction

  task automatic applyStimulus(input logic [15:0] s, input logic [3:0] g, input logic m,
                               input bit useHand, input int hand, input string name, input bit mono);
    exp_t e;
    int   model;
    snd_in = s;
    gain   = g;
    mute   = m;
    model  = modelStep(s, g, m);
    sampIdx++;
    e.pcm  = useHand ? hand : model;
    e.cyc  = TICK_CYC * sampIdx + 3;
    e.name = name;
    e.mono = mono;
    sb.push_back(e);
    while (cyc < TICK_CYC * sampIdx + 10) @(negedge clk);
  endtask

  always @(posedge clk) begin
    #1;
    if (rst) begin
      checkOutput("resetPcmOut", int'(pcm_out), 0);
      checkOutput("resetValid", int'(pcm_valid), 0);
    end else if (pcm_valid) begin
      if (sb.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpectedValid: got pcm_valid with pcm_out %0d, expected no sample (cycle %0d)",
                 $signed(pcm_out), cyc);
      end else begin
        monE = sb.pop_front();
        checkOutput(monE.name, int'($signed(pcm_out)), monE.pcm);
        checkOutput({monE.name, "Cycle"}, cyc, monE.cyc);
        if (monE.mono) begin
          compared++;
          if (!(int'($signed(pcm_out)) <= prevValidOut && int'($signed(pcm_out)) > 0)) begin
            mismatched++;
            $display("[TB] FAIL dcMonotonic: got %0d after %0d, expected positive and non-increasing",
                     $signed(pcm_out), prevValidOut);
          end
        end
      end
      prevValidOut = int'($signed(pcm_out));
    end else begin
      checkOutput("holdPcmOut", int'(pcm_out), int'(heldOut));
    end
    heldOut = pcm_out;
  end

  initial begin
    rst    = 1'b1;
    snd_in = 16'h8000;
    gain   = 4'd8;
    mute   = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 20; i++) applyStimulus(16'h8000, 4'd8, 1'b0, 1'b1, 0, "silence", 1'b0);

    applyStimulus(16'hFFC0, 4'd15, 1'b0, 1'b1, 30660, "satFirst", 1'b0);
    applyStimulus(16'hFFC0, 4'd15, 1'b0, 1'b1, 32767, "satClamp", 1'b0);

    // The low-pass is still catching up for the first few samples of the held step.
    for (int i = 0; i < 150; i++) applyStimulus(16'hFFC0, 4'd8, 1'b0, 1'b0, 0, "dcDecay", i >= 10);

    for (int i = 0; i < 12; i++)
      applyStimulus((i % 2 == 0) ? 16'h8000 : 16'hFFC0, 4'd8, i == 5, i == 5, 0,
                    (i == 5) ? "muted" : "square", 1'b0);

    for (int i = 0; i < 10; i++)
      applyStimulus((i % 2 == 0) ? 16'h8000 : 16'hFFC0, 4'd0, 1'b0, 1'b1, 0, "gainZero", 1'b0);
    for (int i = 0; i < 2; i++)
      applyStimulus((i % 2 == 0) ? 16'h8000 : 16'hFFC0, 4'd8, 1'b0, 1'b0, 0, "gainRestore", 1'b0);

    snd_in = 16'hFFC0;
    while (cyc < TICK_CYC * (sampIdx + 1) + 1) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst     = 1'b0;
    mX      = 0;
    mY      = 0;
    mZ      = 0;
    sampIdx = 0;

    applyStimulus(16'hFFC0, 4'd8, 1'b0, 1'b1, 16352, "postResetFirst", 1'b0);
    applyStimulus(16'hFFC0, 4'd8, 1'b0, 1'b0, 0, "postReset", 1'b0);
    applyStimulus(16'h8000, 4'd8, 1'b0, 1'b0, 0, "postReset", 1'b0);

    repeat (5) @(negedge clk);
    checkOutput("scoreboardDrain", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
